// File: rtl/enemy_slot_scheduler.sv
// Enemy slot scheduler: spawns, moves and retires enemies on fixed lanes, and
// time-shares the single enemy bitmap drawer by picking the covering slot per pixel.
module enemy_slot_scheduler #(
   parameter int unsigned NUM_ENEMIES  = 4,
   parameter int unsigned ENEMY_W      = 32,
   parameter int unsigned ENEMY_H      = 32,
   parameter int unsigned START_X      = 0,
   parameter int unsigned END_X        = 608,
   parameter int unsigned LANE_Y0      = 64,
   parameter int unsigned LANE_PITCH   = 96,
   parameter int unsigned SPAWN_PERIOD = 60,
   parameter int unsigned SPEED        = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   startOfFrame,
   input  logic                   enable,
   input  logic [10:0]            pixelX,
   input  logic [10:0]            pixelY,
   input  logic                   hitValid,
   input  logic [2:0]             hitIndex,
   output logic [10:0]            offsetX,
   output logic [10:0]            offsetY,
   output logic                   InsideRectangle,
   output logic [NUM_ENEMIES-1:0] activeMask,
   output logic [3:0]             aliveCount,
   output logic                   escapePulse,
   output logic                   killPulse
);

   localparam int unsigned IdxW = $clog2(NUM_ENEMIES);
   localparam int unsigned CntW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

   logic [NUM_ENEMIES-1:0] moving_q, moving_d;
   logic [10:0]            x_q [NUM_ENEMIES];
   logic [10:0]            x_d [NUM_ENEMIES];
   logic [CntW-1:0]        frame_cnt_q, frame_cnt_d;
   logic [3:0]             alive_q, alive_d;
   logic                   escape_q, kill_q, kill_d;
   logic [NUM_ENEMIES-1:0] escape_vec;
   logic [10:0]            off_x_q, off_x_d, off_y_q, off_y_d;
   logic                   inside_q, inside_d;

   logic                   tick;
   logic                   spawned;
   logic [11:0]            nx;
   logic [11:0]            lane_y;
   logic [IdxW-1:0]        hit_idx;
   logic                   hit_ok;
   logic                   unused_hit_bits;

   assign tick            = startOfFrame & enable;
   assign hit_idx         = hitIndex[IdxW-1:0];
   assign hit_ok          = int'(hit_idx) < int'(NUM_ENEMIES);
   assign unused_hit_bits = ^hitIndex;

   always_comb begin
      moving_d    = moving_q;
      x_d         = x_q;
      frame_cnt_d = frame_cnt_q;
      escape_vec  = '0;
      kill_d      = 1'b0;
      spawned     = 1'b0;
      nx          = '0;
      alive_d     = '0;

      if (tick) begin
         for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            if (moving_q[i]) begin
               nx = {1'b0, x_q[i]} + 12'(SPEED);
               if (nx >= 12'(END_X)) begin
                  moving_d[i]   = 1'b0;
                  escape_vec[i] = 1'b1;
               end else begin
                  x_d[i] = nx[10:0];
               end
            end
         end
         // Spawn looks only at pre-tick state so a slot that just escaped stays free.
         if (frame_cnt_q == CntW'(SPAWN_PERIOD - 1)) begin
            frame_cnt_d = '0;
            for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
               if (!spawned && !moving_q[i]) begin
                  moving_d[i] = 1'b1;
                  x_d[i]      = 11'(START_X);
                  spawned     = 1'b1;
               end
            end
         end else begin
            frame_cnt_d = frame_cnt_q + CntW'(1);
         end
      end

      // A hit overrides an escape on the same slot.
      if (hitValid && hit_ok && moving_q[hit_idx]) begin
         moving_d[hit_idx]   = 1'b0;
         escape_vec[hit_idx] = 1'b0;
         kill_d              = 1'b1;
      end

      for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
         alive_d = alive_d + 4'(moving_d[i]);
      end
   end

   always_comb begin
      inside_d = 1'b0;
      off_x_d  = '0;
      off_y_d  = '0;
      lane_y   = '0;
      for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
         lane_y = 12'(LANE_Y0 + LANE_PITCH * unsigned'(i));
         if (!inside_d && moving_q[i] &&
             ({1'b0, pixelX} >= {1'b0, x_q[i]}) &&
             ({1'b0, pixelX} <  {1'b0, x_q[i]} + 12'(ENEMY_W)) &&
             ({1'b0, pixelY} >= lane_y) &&
             ({1'b0, pixelY} <  lane_y + 12'(ENEMY_H))) begin
            inside_d = 1'b1;
            off_x_d  = pixelX - x_q[i];
            off_y_d  = pixelY - lane_y[10:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         moving_q    <= '0;
         frame_cnt_q <= '0;
         alive_q     <= '0;
         escape_q    <= 1'b0;
         kill_q      <= 1'b0;
         off_x_q     <= '0;
         off_y_q     <= '0;
         inside_q    <= 1'b0;
         for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            x_q[i] <= '0;
         end
      end else begin
         moving_q    <= moving_d;
         frame_cnt_q <= frame_cnt_d;
         alive_q     <= alive_d;
         escape_q    <= |escape_vec;
         kill_q      <= kill_d;
         off_x_q     <= off_x_d;
         off_y_q     <= off_y_d;
         inside_q    <= inside_d;
         for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            x_q[i] <= x_d[i];
         end
      end
   end

   assign activeMask      = moving_q;
   assign aliveCount      = alive_q;
   assign escapePulse     = escape_q;
   assign killPulse       = kill_q;
   assign offsetX         = off_x_q;
   assign offsetY         = off_y_q;
   assign InsideRectangle = inside_q;

endmodule

// File: tb/tb_enemy_slot_scheduler.sv
// Directed self-checking bench for enemy_slot_scheduler with default parameters.
module tb_enemy_slot_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        startOfFrame = 1'b0;
   logic        enable = 1'b1;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic        hitValid = 1'b0;
   logic [2:0]  hitIndex = '0;
   logic [10:0] offsetX, offsetY;
   logic        InsideRectangle;
   logic [3:0]  activeMask;
   logic [3:0]  aliveCount;
   logic        escapePulse, killPulse;

   int n_checks = 0;
   int n_fail   = 0;

   enemy_slot_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .startOfFrame    (startOfFrame),
      .enable          (enable),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .hitValid        (hitValid),
      .hitIndex        (hitIndex),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .InsideRectangle (InsideRectangle),
      .activeMask      (activeMask),
      .aliveCount      (aliveCount),
      .escapePulse     (escapePulse),
      .killPulse       (killPulse)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk) startOfFrame = 1'b1;
         @(negedge clk) startOfFrame = 1'b0;
      end
   endtask

   task automatic hit(input logic [2:0] idx);
      @(negedge clk) begin hitValid = 1'b1; hitIndex = idx; end
      @(negedge clk) hitValid = 1'b0;
   endtask

   task automatic set_pixel(input int x, input int y);
      @(negedge clk) begin pixelX = 11'(x); pixelY = 11'(y); end
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (activeMask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", activeMask); end
      n_checks++; if (aliveCount !== 4'd0) begin n_fail++; $display("FAIL reset_alive: got %0d want 0", aliveCount); end
      n_checks++; if (InsideRectangle !== 1'b0 || offsetX !== 11'd0 || offsetY !== 11'd0) begin n_fail++; $display("FAIL reset_pixel: got inside=%b ox=%0d oy=%0d want 0 0 0", InsideRectangle, offsetX, offsetY); end
      n_checks++; if (escapePulse !== 1'b0 || killPulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got esc=%b kill=%b want 0 0", escapePulse, killPulse); end
   endtask

   // T counts enabled frame ticks since reset; first spawn at T=60.
   task automatic test_spawn;
      ticks(59);
      n_checks++; if (activeMask !== 4'b0000) begin n_fail++; $display("FAIL spawn_early: got %b want 0000", activeMask); end
      ticks(1);
      n_checks++; if (activeMask !== 4'b0001) begin n_fail++; $display("FAIL spawn_mask: got %b want 0001", activeMask); end
      n_checks++; if (aliveCount !== 4'd1) begin n_fail++; $display("FAIL spawn_alive: got %0d want 1", aliveCount); end
   endtask

   task automatic test_pixel;
      ticks(10);  // T=70, x0=20
      set_pixel(25, 70);
      n_checks++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd5 || offsetY !== 11'd6) begin n_fail++; $display("FAIL pixel_in: got inside=%b ox=%0d oy=%0d want 1 5 6", InsideRectangle, offsetX, offsetY); end
      set_pixel(52, 70);
      n_checks++; if (InsideRectangle !== 1'b0 || offsetX !== 11'd0 || offsetY !== 11'd0) begin n_fail++; $display("FAIL pixel_right_edge: got inside=%b ox=%0d oy=%0d want 0 0 0", InsideRectangle, offsetX, offsetY); end
      set_pixel(51, 95);
      n_checks++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd31 || offsetY !== 11'd31) begin n_fail++; $display("FAIL pixel_corner: got inside=%b ox=%0d oy=%0d want 1 31 31", InsideRectangle, offsetX, offsetY); end
   endtask

   task automatic test_full_and_hit;
      ticks(229);  // T=299
      n_checks++; if (activeMask !== 4'b1111 || aliveCount !== 4'd4) begin n_fail++; $display("FAIL full_mask: got %b/%0d want 1111/4", activeMask, aliveCount); end
      ticks(1);    // T=300, spawn dropped
      n_checks++; if (activeMask !== 4'b1111) begin n_fail++; $display("FAIL drop_mask: got %b want 1111", activeMask); end
      hit(3'd2);
      n_checks++; if (activeMask !== 4'b1011 || killPulse !== 1'b1) begin n_fail++; $display("FAIL hit2: got mask=%b kill=%b want 1011 1", activeMask, killPulse); end
      @(negedge clk);
      n_checks++; if (killPulse !== 1'b0) begin n_fail++; $display("FAIL hit2_width: got kill=%b want 0", killPulse); end
      hit(3'd2);
      n_checks++; if (killPulse !== 1'b0 || activeMask !== 4'b1011) begin n_fail++; $display("FAIL hit_idle: got kill=%b mask=%b want 0 1011", killPulse, activeMask); end
      ticks(59);   // T=359
      n_checks++; if (activeMask !== 4'b1011) begin n_fail++; $display("FAIL wrap_early: got %b want 1011", activeMask); end
      ticks(1);    // T=360, respawn into slot 2 shows counter wrapped at T=300
      n_checks++; if (activeMask !== 4'b1111) begin n_fail++; $display("FAIL wrap_spawn: got %b want 1111", activeMask); end
   endtask

   task automatic test_escape;
      ticks(3);    // T=363, x0=606
      n_checks++; if (escapePulse !== 1'b0) begin n_fail++; $display("FAIL esc_early: got %b want 0", escapePulse); end
      ticks(1);    // T=364
      n_checks++; if (escapePulse !== 1'b1 || killPulse !== 1'b0) begin n_fail++; $display("FAIL esc_pulse: got esc=%b kill=%b want 1 0", escapePulse, killPulse); end
      n_checks++; if (activeMask !== 4'b1110 || aliveCount !== 4'd3) begin n_fail++; $display("FAIL esc_mask: got %b/%0d want 1110/3", activeMask, aliveCount); end
      @(negedge clk);
      n_checks++; if (escapePulse !== 1'b0) begin n_fail++; $display("FAIL esc_width: got %b want 0", escapePulse); end
   endtask

   task automatic test_hit_escape_tie;
      ticks(59);   // T=423, slot0 respawned at 420, x1=606
      n_checks++; if (activeMask !== 4'b1111) begin n_fail++; $display("FAIL tie_pre: got %b want 1111", activeMask); end
      @(negedge clk) begin startOfFrame = 1'b1; hitValid = 1'b1; hitIndex = 3'd1; end
      @(negedge clk) begin startOfFrame = 1'b0; hitValid = 1'b0; end
      n_checks++; if (killPulse !== 1'b1 || escapePulse !== 1'b0) begin n_fail++; $display("FAIL tie_pulses: got kill=%b esc=%b want 1 0", killPulse, escapePulse); end
      n_checks++; if (activeMask !== 4'b1101 || aliveCount !== 4'd3) begin n_fail++; $display("FAIL tie_mask: got %b/%0d want 1101/3", activeMask, aliveCount); end
   endtask

   task automatic test_lane3_pixel;
      set_pixel(368, 352);  // x3=368, lane3 Y=352
      n_checks++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd0 || offsetY !== 11'd0) begin n_fail++; $display("FAIL lane3_origin: got inside=%b ox=%0d oy=%0d want 1 0 0", InsideRectangle, offsetX, offsetY); end
      set_pixel(399, 383);
      n_checks++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd31 || offsetY !== 11'd31) begin n_fail++; $display("FAIL lane3_corner: got inside=%b ox=%0d oy=%0d want 1 31 31", InsideRectangle, offsetX, offsetY); end
      set_pixel(399, 384);
      n_checks++; if (InsideRectangle !== 1'b0 || offsetY !== 11'd0) begin n_fail++; $display("FAIL lane3_bottom: got inside=%b oy=%0d want 0 0", InsideRectangle, offsetY); end
   endtask

   task automatic test_freeze;
      enable = 1'b0;
      ticks(100);
      n_checks++; if (activeMask !== 4'b1101) begin n_fail++; $display("FAIL freeze_mask: got %b want 1101", activeMask); end
      hit(3'd3);
      n_checks++; if (activeMask !== 4'b0101 || killPulse !== 1'b1) begin n_fail++; $display("FAIL freeze_hit: got mask=%b kill=%b want 0101 1", activeMask, killPulse); end
      set_pixel(10, 64);  // x0 frozen at 8
      n_checks++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd2 || offsetY !== 11'd0) begin n_fail++; $display("FAIL freeze_pixel: got inside=%b ox=%0d oy=%0d want 1 2 0", InsideRectangle, offsetX, offsetY); end
   endtask

   task automatic test_mid_reset;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++; if (activeMask !== 4'b0000 || aliveCount !== 4'd0) begin n_fail++; $display("FAIL async_mask: got %b/%0d want 0000/0", activeMask, aliveCount); end
      n_checks++; if (InsideRectangle !== 1'b0 || offsetX !== 11'd0 || offsetY !== 11'd0) begin n_fail++; $display("FAIL async_pixel: got inside=%b ox=%0d oy=%0d want 0 0 0", InsideRectangle, offsetX, offsetY); end
      @(negedge clk) reset = 1'b0;
      enable = 1'b1;
      ticks(59);
      n_checks++; if (activeMask !== 4'b0000) begin n_fail++; $display("FAIL rst_spawn_early: got %b want 0000", activeMask); end
      ticks(1);
      n_checks++; if (activeMask !== 4'b0001 || aliveCount !== 4'd1) begin n_fail++; $display("FAIL rst_spawn: got %b/%0d want 0001/1", activeMask, aliveCount); end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_pixel();
      test_full_and_hit();
      test_escape();
      test_hit_escape_tie();
      test_lane3_pixel();
      test_freeze();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
